// File: rtl/heap_alloc_pkg.sv
// Package lisp: heap layout constants, object type tags and the object-size
// helper shared between the allocator and the fetch side.
package lisp;

  localparam int unsigned addr_width = 16;
  localparam int unsigned data_width = 16;

  localparam logic [addr_width-1:0] heap_base  = 16'h0100;
  localparam logic [addr_width-1:0] heap_limit = 16'h7FFF;

  localparam logic [data_width-1:0] TYPE_NUMBER    = 16'h0001;
  localparam logic [data_width-1:0] TYPE_CONS      = 16'h0002;
  localparam logic [data_width-1:0] TYPE_FUNC_PRIM = 16'h0003;

  // Words occupied by an object of the given tag (tag word included);
  // 0 marks a tag the heap does not know how to lay out.
  function automatic logic [1:0] obj_size(input logic [data_width-1:0] tag);
    logic [1:0] sz;
    sz = 2'd0;
    case (tag)
      TYPE_NUMBER:    sz = 2'd2;
      TYPE_FUNC_PRIM: sz = 2'd2;
      TYPE_CONS:      sz = 2'd3;
      default:        sz = 2'd0;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/heap_alloc.sv
// heap_alloc: bump-pointer object allocator. Writes tag, w0 and (cons only)
// w1 one word per cycle starting at the current free pointer.
// Optional build macro HEAP_ALLOC_STATS_EN enables the saturating
// successful-allocation counter on alloc_count.
module heap_alloc
  import lisp::*;
#(
  parameter int unsigned ADDR_WIDTH = lisp::addr_width,
  parameter int unsigned DATA_WIDTH = lisp::data_width,
  parameter logic [ADDR_WIDTH-1:0] HEAP_BASE  = lisp::heap_base,
  parameter logic [ADDR_WIDTH-1:0] HEAP_LIMIT = lisp::heap_limit
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req,
  input  logic [DATA_WIDTH-1:0] alloc_tag,
  input  logic [DATA_WIDTH-1:0] alloc_w0,
  input  logic [DATA_WIDTH-1:0] alloc_w1,
  output logic                  alloc_ready,
  output logic                  alloc_done,
  output logic [ADDR_WIDTH-1:0] alloc_addr,
  output logic                  alloc_err,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] heap_ptr,
  output logic [15:0]           alloc_count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_error
);

  localparam int unsigned AW1 = ADDR_WIDTH + 1;
  localparam int unsigned TW  = lisp::data_width;

  typedef enum logic [2:0] {
    IDLE,
    WR_TAG,
    WR_W0,
    WR_W1,
    DONE,
    FAULT
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] tag_q, w0_q, w1_q;
  logic [ADDR_WIDTH-1:0] obj_addr;
  logic [1:0]            size_q;
  logic                  err_q;
  logic [1:0]            req_size;
  logic [AW1-1:0]        req_end;
  logic                  req_ok;

  // Size and fit check of the incoming request; one extra bit keeps the
  // end address from wrapping past the top of the address space.
  always_comb begin
    req_size = obj_size(TW'(alloc_tag));
    req_end  = {1'b0, heap_ptr} + AW1'(req_size) - AW1'(1);
    req_ok   = (req_size != 2'd0) && (req_end <= {1'b0, HEAP_LIMIT});
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: a memory error in any write state latches FAULT until reset.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (alloc_req && req_ok) state_nxt = WR_TAG;
      WR_TAG:  state_nxt = mem_error ? FAULT : WR_W0;
      WR_W0:   if (mem_error)           state_nxt = FAULT;
               else if (size_q == 2'd3) state_nxt = WR_W1;
               else                     state_nxt = DONE;
      WR_W1:   state_nxt = mem_error ? FAULT : DONE;
      DONE:    state_nxt = IDLE;
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, reject pulse and free pointer; the pointer only moves in
  // DONE, so an object abandoned by reset or fault never consumes space.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q    <= '0;
      w0_q     <= '0;
      w1_q     <= '0;
      obj_addr <= '0;
      size_q   <= '0;
      err_q    <= 1'b0;
      heap_ptr <= HEAP_BASE;
    end else begin
      err_q <= 1'b0;
      if (state == IDLE && alloc_req) begin
        tag_q    <= alloc_tag;
        w0_q     <= alloc_w0;
        w1_q     <= alloc_w1;
        obj_addr <= heap_ptr;
        size_q   <= req_size;
        err_q    <= !req_ok;
      end
      if (state == DONE) heap_ptr <= obj_addr + ADDR_WIDTH'(size_q);
    end
  end

  // Outputs decoded from state so reset removes the write strobe at once.
  always_comb begin
    alloc_ready      = (state == IDLE);
    alloc_done       = (state == DONE);
    alloc_addr       = '0;
    alloc_err        = err_q;
    fault            = (state == FAULT);
    mem_addr         = '0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    case (state)
      WR_TAG: begin
        mem_write_enable = 1'b1;
        mem_addr         = obj_addr;
        mem_write_data   = tag_q;
      end
      WR_W0: begin
        mem_write_enable = 1'b1;
        mem_addr         = obj_addr + ADDR_WIDTH'(1);
        mem_write_data   = w0_q;
      end
      WR_W1: begin
        mem_write_enable = 1'b1;
        mem_addr         = obj_addr + ADDR_WIDTH'(2);
        mem_write_data   = w1_q;
      end
      DONE:    alloc_addr = obj_addr;
      default: ;
    endcase
  end

`ifdef HEAP_ALLOC_STATS_EN
  logic [15:0] count_q;

  // Saturating count of completed allocations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    count_q <= '0;
    else if (state == DONE && count_q != '1)    count_q <= count_q + 16'd1;
  end

  assign alloc_count = count_q;
`else
  assign alloc_count = '0;
`endif

endmodule

// File: tb/tb_heap_alloc.sv
// Self-checking bench for heap_alloc (16-bit, heap 0x0100..0x0104).
module tb_heap_alloc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_req = 1'b0;
  logic [15:0] alloc_tag = '0, alloc_w0 = '0, alloc_w1 = '0;
  logic        alloc_ready, alloc_done, alloc_err, fault;
  logic [15:0] alloc_addr, heap_ptr, alloc_count, mem_addr, mem_write_data;
  logic        mem_write_enable;
  logic        mem_error = 1'b0;

  always #5 clk = ~clk;

  heap_alloc #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(16),
    .HEAP_BASE (16'h0100),
    .HEAP_LIMIT(16'h0104)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_req       (alloc_req),
    .alloc_tag       (alloc_tag),
    .alloc_w0        (alloc_w0),
    .alloc_w1        (alloc_w1),
    .alloc_ready     (alloc_ready),
    .alloc_done      (alloc_done),
    .alloc_addr      (alloc_addr),
    .alloc_err       (alloc_err),
    .fault           (fault),
    .heap_ptr        (heap_ptr),
    .alloc_count     (alloc_count),
    .mem_addr        (mem_addr),
    .mem_write_enable(mem_write_enable),
    .mem_write_data  (mem_write_data),
    .mem_error       (mem_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed { logic [15:0] addr; logic [15:0] data; } wr_t;
  typedef struct packed { logic is_err; logic [15:0] addr; } cpl_t;
  wr_t  wr_q[$];
  cpl_t cpl_q[$];

`ifdef HEAP_ALLOC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // Scoreboard monitor: every write and every done/err pulse must match
  // the next expectation queued by the driver.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_write_enable) begin
        check_eq("wr_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          wr_t w;
          w = wr_q.pop_front();
          check_eq("wr_addr", 32'(mem_addr), 32'(w.addr));
          check_eq("wr_data", 32'(mem_write_data), 32'(w.data));
        end
      end
      if (alloc_done || alloc_err) begin
        check_eq("cpl_expected", 32'(cpl_q.size() != 0), 32'd1);
        check_eq("done_err_exclusive", 32'(alloc_done && alloc_err), 32'd0);
        if (cpl_q.size() != 0) begin
          cpl_t c;
          c = cpl_q.pop_front();
          check_eq("cpl_kind", 32'(alloc_err), 32'(c.is_err));
          check_eq("cpl_addr", 32'(alloc_addr), 32'(c.addr));
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!alloc_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", 32'(alloc_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_ready", 32'(alloc_ready), 32'd1);
    check_eq("rst_ptr", 32'(heap_ptr), 32'h0100);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_count", 32'(alloc_count), 32'd0);
    check_eq("rst_outs", {alloc_done, alloc_err, mem_write_enable, alloc_addr, mem_addr}, 32'd0);
  endtask

  // Issue one request; exp_lat is the cycle of done/err counting the accept
  // cycle as 0. hold keeps alloc_req high while busy (must be ignored).
  task automatic do_alloc(input string name, input logic [15:0] tag, input logic [15:0] w0,
                          input logic [15:0] w1, input bit exp_err, input logic [15:0] exp_addr,
                          input int exp_lat, input bit hold);
    int n;
    int nw;
    cpl_t c;
    wr_t w;
    logic [15:0] words [3];
    wait_ready();
    words[0] = tag; words[1] = w0; words[2] = w1;
    nw = exp_err ? 0 : exp_lat - 1;
    for (int i = 0; i < nw; i++) begin
      w.addr = exp_addr + 16'(i);
      w.data = words[i];
      wr_q.push_back(w);
    end
    c.is_err = exp_err;
    c.addr   = exp_err ? 16'h0000 : exp_addr;
    cpl_q.push_back(c);
    alloc_req = 1'b1;
    alloc_tag = tag; alloc_w0 = w0; alloc_w1 = w1;
    @(posedge clk);
    n = 1;
    if (!hold) #1 alloc_req = 1'b0;
    @(negedge clk);
    while (!(alloc_done || alloc_err) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq({name, "_latency"}, 32'(n), 32'(exp_lat));
    alloc_req = 1'b0;
    @(negedge clk);
    check_eq({name, "_pulse_end"}, {alloc_done, alloc_err}, 32'd0);
    check_eq({name, "_ready_after"}, 32'(alloc_ready), 32'd1);
  endtask

  initial begin
    wr_t w;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("init_ready", 32'(alloc_ready), 32'd1);
    check_eq("init_ptr", 32'(heap_ptr), 32'h0100);
    check_eq("init_outs", {alloc_done, alloc_err, fault, mem_write_enable, alloc_addr}, 32'd0);
    check_eq("init_count", 32'(alloc_count), 32'd0);

    do_alloc("number", 16'h0001, 16'h002A, 16'h0000, 1'b0, 16'h0100, 3, 1'b0);
    check_eq("number_ptr", 32'(heap_ptr), 32'h0102);
    do_alloc("cons", 16'h0002, 16'h0100, 16'h0000, 1'b0, 16'h0102, 4, 1'b1);
    check_eq("cons_ptr", 32'(heap_ptr), 32'h0105);
    do_alloc("full", 16'h0001, 16'h0005, 16'h0000, 1'b1, 16'h0000, 1, 1'b0);
    check_eq("full_ptr", 32'(heap_ptr), 32'h0105);
    do_alloc("badtag", 16'h00EE, 16'h0007, 16'h0000, 1'b1, 16'h0000, 1, 1'b0);
    check_eq("badtag_ptr", 32'(heap_ptr), 32'h0105);
    check_eq("count_two", 32'(alloc_count), STATS ? 32'd2 : 32'd0);

    // Memory error while writing w0 -> sticky fault.
    do_reset();
    w.addr = 16'h0100; w.data = 16'h0001; wr_q.push_back(w);
    w.addr = 16'h0101; w.data = 16'h1234; wr_q.push_back(w);
    alloc_req = 1'b1; alloc_tag = 16'h0001; alloc_w0 = 16'h1234; alloc_w1 = 16'h0000;
    @(posedge clk);
    #1 alloc_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mem_error = 1'b1;
    @(negedge clk);
    mem_error = 1'b0;
    check_eq("fault_set", 32'(fault), 32'd1);
    check_eq("fault_ready", 32'(alloc_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      alloc_req = 1'b1;
      @(negedge clk);
      check_eq("fault_sticky", {fault, alloc_ready, mem_write_enable, alloc_done}, 32'h8);
      check_eq("fault_ptr", 32'(heap_ptr), 32'h0100);
    end
    alloc_req = 1'b0;
    do_reset();

    // Reset while writing the cdr of a cons.
    do_alloc("number2", 16'h0001, 16'h002A, 16'h0000, 1'b0, 16'h0100, 3, 1'b0);
    w.addr = 16'h0102; w.data = 16'h0002; wr_q.push_back(w);
    w.addr = 16'h0103; w.data = 16'h0100; wr_q.push_back(w);
    w.addr = 16'h0104; w.data = 16'h0000; wr_q.push_back(w);
    alloc_req = 1'b1; alloc_tag = 16'h0002; alloc_w0 = 16'h0100; alloc_w1 = 16'h0000;
    @(posedge clk);
    #1 alloc_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_eq("w1_we", 32'(mem_write_enable), 32'd1);
    #1 rst = 1'b1;
    #1 check_eq("rst_async_we", 32'(mem_write_enable), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_eq("abandon_ptr", 32'(heap_ptr), 32'h0100);
    check_eq("abandon_count", 32'(alloc_count), 32'd0);
    check_eq("abandon_done", {alloc_done, alloc_err}, 32'd0);
    do_alloc("number3", 16'h0003, 16'h0BAD, 16'h0000, 1'b0, 16'h0100, 3, 1'b0);
    check_eq("number3_ptr", 32'(heap_ptr), 32'h0102);
    check_eq("count_one", 32'(alloc_count), STATS ? 32'd1 : 32'd0);

    repeat (2) @(negedge clk);
    check_eq("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    check_eq("cpl_queue_drained", 32'(cpl_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
